// File: rtl/id_token_stat.sv
// id_token_stat: tracks identifier tokens alongside an upstream recognizer and keeps length/count statistics
module id_token_stat #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       char,
  input  logic             match,
  input  logic             clear,
  output logic [CNT_W-1:0] id_count,
  output logic [7:0]       last_len,
  output logic [7:0]       max_len,
  output logic             id_done,
  output logic             sync_err
);
  typedef enum logic [1:0] {IDLE, ALPHA, NUM} trk_t;
  trk_t trk, trk_nx;
  logic [7:0] run_len, run_nx;
  logic is_let, is_dig, term, desync;
  always_comb begin
    is_let = (char >= "a" && char <= "z") || (char >= "A" && char <= "Z");
    is_dig = char >= "0" && char <= "9";
    term   = match && !is_let && !is_dig;
    desync = match != (trk == NUM);
    trk_nx = is_let ? ALPHA : (is_dig && trk != IDLE) ? NUM : IDLE;
    run_nx = (!is_let && !is_dig) || (trk == IDLE && is_dig) ? 8'd0 :
             trk == IDLE ? 8'd1 :
             run_len == 8'd255 ? 8'd255 : run_len + 8'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk     <= IDLE;
      run_len <= '0;
    end else if (clear) begin
      trk     <= IDLE;
      run_len <= '0;
    end else begin
      trk     <= trk_nx;
      run_len <= run_nx;
    end
  end
  // a clear in the same cycle as a terminator wins, so the token is never counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_count <= '0;
      last_len <= '0;
      max_len  <= '0;
      id_done  <= 1'b0;
      sync_err <= 1'b0;
    end else if (clear) begin
      id_count <= '0;
      last_len <= '0;
      max_len  <= '0;
      id_done  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      id_done  <= term;
      sync_err <= sync_err | desync;
      if (term) begin
        id_count <= id_count + CNT_W'(id_count != '1);
        last_len <= run_len;
        max_len  <= run_len > max_len ? run_len : max_len;
      end
    end
  end
endmodule

// File: tb/tb_id_token_stat.sv
// tb_id_token_stat: directed scenarios plus random streams checked against a word-level model
module tb_id_token_stat;
  localparam int CW = 4;
  logic clk = 0, reset_n = 0, match = 0, clear = 0;
  logic [7:0] char = 0;
  logic [CW-1:0] id_count;
  logic [7:0] last_len, max_len;
  logic id_done, sync_err;
  int total = 0, bad = 0;
  byte unsigned word[$];
  int m_cnt, m_last, m_max;
  bit m_done, m_err;

  id_token_stat #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .char(char), .match(match), .clear(clear),
    .id_count(id_count), .last_len(last_len), .max_len(max_len),
    .id_done(id_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  function automatic bit is_let(byte unsigned c);
    return (c >= 97 && c <= 122) || (c >= 65 && c <= 90);
  endfunction
  function automatic bit is_dig(byte unsigned c);
    return c >= 48 && c <= 57;
  endfunction
  function automatic bit is_oth(byte unsigned c);
    return !is_let(c) && !is_dig(c);
  endfunction
  // identifier so far = everything from the first letter of the current word
  function automatic int first_let();
    for (int i = 0; i < word.size(); i++) if (is_let(word[i])) return i;
    return -1;
  endfunction
  function automatic int tok_len();
    int f = first_let();
    if (f < 0) return 0;
    return (word.size() - f) > 255 ? 255 : word.size() - f;
  endfunction
  function automatic bit q_num();
    return first_let() >= 0 && is_dig(word[word.size()-1]);
  endfunction

  task automatic model_zero();
    m_cnt = 0; m_last = 0; m_max = 0; m_done = 0; m_err = 0;
    word.delete();
  endtask

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cnt"}, int'(id_count), m_cnt);
    check({tag, "_last"}, int'(last_len), m_last);
    check({tag, "_max"}, int'(max_len), m_max);
    check({tag, "_done"}, int'(id_done), int'(m_done));
    check({tag, "_err"}, int'(sync_err), int'(m_err));
  endtask

  task automatic step(input byte unsigned c, input bit m, input bit cl, input string tag);
    bit term;
    term = m && is_oth(c);
    char = c; match = m; clear = cl;
    if (cl) model_zero();
    else begin
      if (m != q_num()) m_err = 1;
      m_done = term;
      if (term) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_last = tok_len();
        if (m_last > m_max) m_max = m_last;
      end
      if (is_oth(c)) word.delete();
      else word.push_back(c);
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic feed(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(s[i], q_num(), 0, tag);
  endtask

  initial begin
    byte unsigned c;
    int r;
    model_zero();
    char = 8'($urandom);
    match = 1;
    repeat (3) @(posedge clk);
    #1 check_all("rst");
    @(negedge clk) reset_n = 1;

    feed("ab12 ", "r27");
    check("r27_cnt_k", int'(id_count), 1);
    check("r27_last_k", int'(last_len), 4);
    check("r27_done_k", int'(id_done), 1);
    step(" ", 0, 0, "r27b");
    check("r27_pulse_k", int'(id_done), 0);

    step(" ", 0, 1, "clr");
    feed("x9;ab;", "r28");
    check("r28_cnt_k", int'(id_count), 1);
    check("r28_last_k", int'(last_len), 2);

    step(" ", 0, 1, "clr");
    feed("7a1 ", "r29");
    check("r29_cnt_k", int'(id_count), 1);
    check("r29_last_k", int'(last_len), 2);

    step(" ", 0, 1, "clr");
    repeat (300) step("a", q_num(), 0, "r30");
    feed("5.", "r30");
    check("r30_last_k", int'(last_len), 255);
    check("r30_cnt_k", int'(id_count), 1);

    step(" ", 0, 1, "clr");
    feed("ab1", "r31");
    step(" ", 1, 1, "r31t");
    check("r31_cnt_k", int'(id_count), 0);
    check("r31_done_k", int'(id_done), 0);
    step(" ", 1, 0, "r31f");
    check("r31_err_k", int'(sync_err), 1);
    feed("xy ", "r31s");
    check("r31_sticky_k", int'(sync_err), 1);
    step(" ", 0, 1, "r31c");
    check("r31_clr_k", int'(sync_err), 0);

    feed("zz9 ", "r32a");
    feed("ab", "r32");
    char = "1"; match = 0; clear = 0;
    @(posedge clk); #3 reset_n = 0;
    #1;
    model_zero();
    check_all("r32_async");
    @(negedge clk) reset_n = 1;
    feed("c2 ", "r32b");
    check("r32_cnt_k", int'(id_count), 1);
    check("r32_last_k", int'(last_len), 2);

    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 9);
      c = r < 4 ? 8'(97 + $urandom_range(0, 25)) : r < 5 ? 8'(65 + $urandom_range(0, 25)) :
          r < 7 ? 8'(48 + $urandom_range(0, 9)) : r < 8 ? 8'd32 : r < 9 ? 8'd59 : 8'($urandom_range(0, 255));
      step(c, q_num() ^ ($urandom_range(0, 99) == 0), $urandom_range(0, 199) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_token_stat.md
ID_TOKEN_STAT -- requirements
Module: id_token_stat

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the identifier counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port char  input  8  ASCII character of the current cycle, the same byte presented to the upstream identifier recognizer this cycle.
REQ-005 SHALL have port match  input  1  recognizer output this cycle; high = "letters then digits" pattern ended on the previous cycle's char.
REQ-006 SHALL have port clear  input  1  synchronous clear of statistics.
REQ-007 SHALL have port id_count  output  CNT_W  number of completed identifiers, saturating.
REQ-008 SHALL have port last_len  output  8  length of the most recently completed identifier.
REQ-009 SHALL have port max_len  output  8  longest completed identifier length since reset/clear.
REQ-010 SHALL have port id_done  output  1  one-cycle pulse, registered, one cycle after a terminator closes an identifier.
REQ-011 SHALL have port sync_err  output  1  sticky flag: internal tracker disagrees with match.

Function
REQ-012 SHALL classify char: LETTER = "a".."z" or "A".."Z"; DIGIT = "0".."9"; OTHER = all remaining codes.
REQ-013 SHALL hold internal state trk in {IDLE, ALPHA, NUM} plus run_len[7:0].
REQ-014 SHALL update trk per char: any state + LETTER -> ALPHA; IDLE + DIGIT -> IDLE; ALPHA/NUM + DIGIT -> NUM; any state + OTHER -> IDLE.
REQ-015 SHALL update run_len per char: OTHER -> 0; IDLE + DIGIT -> 0; IDLE + LETTER -> 1; otherwise run_len+1, saturating at 255.
REQ-016 SHALL detect a terminator when match=1 and char is OTHER in the same cycle; run_len at that cycle is the identifier length.
REQ-017 SHALL, on terminator, next cycle: id_count+1 (saturate at 2^CNT_W-1), last_len <= run_len, max_len <= max(max_len, run_len), id_done=1.
REQ-018 SHALL keep id_done low in every cycle not immediately following a terminator; back-to-back terminators impossible (OTHER forces match=0 next cycle).
REQ-019 SHALL not count a token when match=1 and char is LETTER or DIGIT (token still open).
REQ-020 SHALL set sync_err (sticky) on any cycle where match != (trk==NUM); cleared only by reset or clear.
REQ-021 SHALL, when clear=1: zero id_count, last_len, max_len, sync_err, id_done, trk <= IDLE, run_len <= 0 next cycle; clear overrides a simultaneous terminator (not counted); char of that cycle discarded.
REQ-022 SHALL drive all outputs directly from registers.
REQ-023 SHALL produce identical results regardless of char value during reset assertion.

Reset
REQ-024 SHALL, while reset_n=0, force id_count=0, last_len=0, max_len=0, id_done=0, sync_err=0, trk=IDLE, run_len=0 immediately, independent of clk.
REQ-025 SHALL, on reset mid-token, discard the partial token; first post-reset cycle treats char as start of stream.
REQ-026 SHALL require upstream recognizer reset concurrently; match sampled in first cycle after reset release is compared normally.

Verification
REQ-027 SHALL pass: chars "a","b","1","2"," " with matching match stream (0,0,0,1,1) -> id_done pulses once after " ", id_count=1, last_len=4, max_len=4, sync_err=0.
REQ-028 SHALL pass: "x9;" then "ab;" -> id_count=1 (second has no digit), last_len=2.
REQ-029 SHALL pass: "7a1 " -> leading digit ignored, id_count=1, last_len=2.
REQ-030 SHALL pass: 300 letters then "5", "." -> last_len=255 (saturated), id_count=1.
REQ-031 SHALL pass: terminator cycle with clear=1 -> id_count=0, id_done=0 next cycle; forced match=1 on IDLE stream -> sync_err=1 and stays until clear.
REQ-032 SHALL pass: reset_n pulled low mid-cycle during "ab1" -> all outputs 0 before next posedge; subsequent "c2 " yields id_count=1, last_len=2.
